// File: rtl/half_mul_pkg.sv
// Shared constants and the operation-sequencing state type for the
// shared half-format multiplier.
package half_mul_pkg;

    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 11;
    localparam int WORD_W   = 16;
    localparam int MUL_CYC  = 11;
    localparam int NORM_MAX = 10;
    localparam int ACC_W    = 2 * FRAC_W;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        RESP
    } state_e;

endpackage

// File: rtl/half_mul_iter.sv
// Iterative {exp, frac} multiplier core: 11 shift-add cycles, then a
// left-normalise loop of up to 10 shifts, then a one-cycle done pulse.
module half_mul_iter
    import half_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic              done_o,
    output logic [WORD_W-1:0] result_o
);

    localparam int CNT_W = $clog2(MUL_CYC);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0]   fa_q, fa_d;
    logic [FRAC_W-1:0]   fb_q, fb_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                done_q, done_d;
    logic [FRAC_W-1:0]   p;

    // Truncated product: only the upper half of the accumulator matters.
    assign p = acc_q[ACC_W-1 -: FRAC_W];

    // Next-state and datapath for the multiply and normalise phases.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        fa_d     = fa_q;
        fb_d     = fb_q;
        acc_d    = acc_q;
        exp_d    = exp_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    fa_d    = a_i[FRAC_W-1:0];
                    fb_d    = b_i[FRAC_W-1:0];
                    exp_d   = a_i[WORD_W-1 -: EXP_W] + b_i[WORD_W-1 -: EXP_W];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // LSB-first: bit i of frac_b adds frac_a shifted by i.
                if (fb_q[0]) begin
                    acc_d = acc_q + (ACC_W'(fa_q) << cnt_q);
                end
                fb_d  = fb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_CYC - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (p == '0) begin
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (p[FRAC_W-1]) begin
                    result_d = {exp_q, p};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    // Zeros enter from the right: the discarded low half never returns.
                    acc_d = {p[FRAC_W-2:0], 1'b0, acc_q[FRAC_W-1:0]};
                    exp_d = exp_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Core register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            acc_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            acc_q    <= acc_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: rtl/half_mul_sched.sv
// Round-robin front end sharing one half_mul_iter among NREQ requesters,
// with a held response register until the sink accepts.
module half_mul_sched
    import half_mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [WORD_W*NREQ-1:0] req_a,
    input  logic [WORD_W*NREQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_W-1:0]      rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    // MUL here spans the whole core computation (multiply and normalise).
    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]    grant_idx;
    logic              grant_found;
    logic              accept;
    logic              core_done;
    logic [WORD_W-1:0] core_result;
    logic [WORD_W-1:0] a_arr [NREQ];
    logic [WORD_W-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[WORD_W*i +: WORD_W];
        assign b_arr[i] = req_b[WORD_W*i +: WORD_W];
    end

    // Round-robin search: first valid requester from the pointer upward, wrapping.
    always_comb begin : arbiter
        int slot;
        slot        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            slot = int'(ptr_q) + k;
            if (slot >= NREQ) slot = slot - NREQ;
            if (!grant_found && req_valid[slot[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = slot[IDW-1:0];
            end
        end
    end

    // Gating with rst_n keeps req_ready at zero while reset is held.
    assign accept = (state_q == IDLE) && grant_found && rst_n;

    // One-hot ready for the granted requester only.
    always_comb begin : ready_decode
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    // Handshake sequencing: accept, wait for the core, hold the response.
    always_comb begin : fsm_next
        state_d    = state_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d    = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    rsp_id_d = grant_idx;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (core_done) begin
                    rsp_data_d = core_result;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    half_mul_iter u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept),
        .a_i      (a_arr[grant_idx]),
        .b_i      (b_arr[grant_idx]),
        .done_o   (core_done),
        .result_o (core_result)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_half_mul_sched.sv
// Randomised bench for half_mul_sched against a transaction-level model.
module tb_half_mul_sched;
    import half_mul_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = $clog2(NREQ);

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [WORD_W*NREQ-1:0] req_a;
    logic [WORD_W*NREQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [WORD_W-1:0]      rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    half_mul_sched #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference multiply from the arithmetic rules; returns {k, result}.
    function automatic logic [20:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int unsigned prod, p;
        int          e, k;
        logic [4:0]  e5;
        prod = int'(a[10:0]) * int'(b[10:0]);
        p    = prod >> 11;
        e    = int'(a[15:11]) + int'(b[15:11]);
        k    = 0;
        if (p == 0) return 21'd0;
        while (p < 1024) begin
            p = p * 2;
            e = e - 1;
            k++;
        end
        e5 = 5'(e);
        return {5'(k), e5, 11'(p)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [15:0] slot_word(input logic [WORD_W*NREQ-1:0] bus, input int idx);
        return bus[16*idx +: 16];
    endfunction

    function automatic logic [15:0] rand_operand();
        logic [10:0] f;
        f = 11'($urandom_range(0, 2047) >> $urandom_range(0, 10));
        return {5'($urandom), f};
    endfunction

    // Transaction model: phase 0 idle, 1 computing, 2 responding.
    int              m_phase = 0;
    int              m_ptr   = 0;
    int              m_left  = 0;
    int              m_id    = 0;
    logic [15:0]     m_data  = '0;
    int              mg;
    logic [20:0]     mr;
    logic [NREQ-1:0] exp_ready;

    always_comb begin
        mg = rr_pick(req_valid, m_ptr);
        mr = ref_mul(slot_word(req_a, (mg < 0) ? 0 : mg), slot_word(req_b, (mg < 0) ? 0 : mg));
        exp_ready = '0;
        if (rst_n && m_phase == 0 && mg >= 0) exp_ready[mg] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                0: if (mg >= 0) begin
                    m_data  <= mr[15:0];
                    m_id    <= mg;
                    m_left  <= 13 + int'(mr[20:16]);
                    m_ptr   <= (mg + 1) % NREQ;
                    m_phase <= 1;
                end
                1: begin
                    if (m_left == 1) m_phase <= 2;
                    m_left <= m_left - 1;
                end
                default: if (rsp_ready) m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", busy, m_phase != 0);
        check("rsp_valid", rsp_valid, m_phase == 2);
        check("req_ready", req_ready, exp_ready);
        if (m_phase == 2) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input string name, input int slot, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] exp_data, input int exp_lat);
        int lat;
        req_a[16*slot +: 16] = a;
        req_b[16*slot +: 16] = b;
        req_valid            = '0;
        req_valid[slot]      = 1'b1;
        rsp_ready            = 1'b0;
        tick();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
        end
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_data"}, rsp_data, exp_data);
        check({name, "_id"}, rsp_id, slot);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, "_drop"}, rsp_valid, 1'b0);
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_data", rsp_data, 0);
        check("rst_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        check("pin_k1", ref_mul(16'h1C00, 16'h1400), {5'd1, 16'h2400});
        check("pin_k10", ref_mul(16'h0002, 16'h07FF), {5'd10, 16'hB400});

        single_op("op_k1", 0, 16'h1C00, 16'h1400, 16'h2400, 14);
        single_op("op_zero", 0, 16'hF800, 16'hFFFF, 16'h0000, 13);
        single_op("op_wrap", 2, 16'hFFFF, 16'hFFFF, 16'hF7FE, 13);
        single_op("op_k10", 3, 16'h0002, 16'h07FF, 16'hB400, 23);

        // Round-robin with all requesters held valid from reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = rand_operand();
            req_b[16*i +: 16] = rand_operand();
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            int w;
            w = 0;
            while (!rsp_valid && w < 60) begin
                tick();
                w++;
            end
            check("rr_valid", rsp_valid, 1'b1);
            check("rr_id", rsp_id, rr_order[n]);
            if (n == 1) begin
                rsp_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check("hold_valid", rsp_valid, 1'b1);
                    check("hold_data", rsp_data, m_data);
                    check("hold_id", rsp_id, rr_order[n]);
                end
                rsp_ready = 1'b1;
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();

        // Abort a 10-shift operation during normalisation.
        req_a[16 +: 16] = 16'h0002;
        req_b[16 +: 16] = 16'h07FF;
        req_valid       = 4'b0010;
        tick();
        req_valid = '0;
        repeat (15) tick();
        check("abort_busy", busy, 1'b1);
        req_valid = 4'b1010;
        rst_n     = 1'b0;
        #1;
        check("abort_busy0", busy, 1'b0);
        check("abort_valid0", rsp_valid, 1'b0);
        check("abort_ready0", req_ready, 0);
        check("abort_data0", rsp_data, 0);
        check("abort_id0", rsp_id, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (40) tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_a[16*i +: 16] = rand_operand();
                req_b[16*i +: 16] = rand_operand();
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (c == 1500) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (13 + NORM_MAX + 5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
